// File: rtl/control_sequencer_if.sv
// Control bundle between the hardwired sequencer and the single-bus datapath.
// master = sequencer side (drives strobes), slave = datapath side (drives IR/CON/stop).
interface control_sequencer_if;
    logic [31:0] ir;
    logic        con_ff;
    logic        stop;
    logic        PCout, Z_hi_reg_out, Z_lo_reg_out, MDR_reg_out, HI_reg_out;
    logic        LO_reg_out, InPort_out, Cout, BAout, Rout;
    logic        MARin, MDR_reg_in, PCin, IR_reg_in, Y_reg_in, Zin;
    logic        HI_reg_in, LO_reg_in, Rin, CON_enable, Output_in;
    logic        Gra, Grb, Grc;
    logic        IncPC, Read, Write;
    logic [4:0]  opcode;
    logic        run;

    modport master (
        input  ir, con_ff, stop,
        output PCout, Z_hi_reg_out, Z_lo_reg_out, MDR_reg_out, HI_reg_out,
               LO_reg_out, InPort_out, Cout, BAout, Rout,
               MARin, MDR_reg_in, PCin, IR_reg_in, Y_reg_in, Zin,
               HI_reg_in, LO_reg_in, Rin, CON_enable, Output_in,
               Gra, Grb, Grc, IncPC, Read, Write, opcode, run
    );

    modport slave (
        output ir, con_ff, stop,
        input  PCout, Z_hi_reg_out, Z_lo_reg_out, MDR_reg_out, HI_reg_out,
               LO_reg_out, InPort_out, Cout, BAout, Rout,
               MARin, MDR_reg_in, PCin, IR_reg_in, Y_reg_in, Zin,
               HI_reg_in, LO_reg_in, Rin, CON_enable, Output_in,
               Gra, Grb, Grc, IncPC, Read, Write, opcode, run
    );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for the single-bus CPU: fetch T0-T2, decode, execute T3-T7.
// Strobes are registered from a decode of the current step, so they appear one clock after the step is entered.
module control_sequencer #(
    parameter int MEM_WAIT = 0
) (
    input  logic                clk,
    input  logic                clr,
    control_sequencer_if.master bus
);
    typedef enum logic [3:0] {
        S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    typedef struct packed {
        logic PCout, Z_hi_reg_out, Z_lo_reg_out, MDR_reg_out, HI_reg_out;
        logic LO_reg_out, InPort_out, Cout, BAout, Rout;
        logic MARin, MDR_reg_in, PCin, IR_reg_in, Y_reg_in, Zin;
        logic HI_reg_in, LO_reg_in, Rin, CON_enable, Output_in;
        logic Gra, Grb, Grc, IncPC, Read, Write;
        logic [4:0] opcode;
        logic run;
    } ctl_t;

    localparam logic [4:0] OP_LD   = 5'd0,  OP_LDI  = 5'd1,  OP_ST   = 5'd2,  OP_ADD  = 5'd3;
    localparam logic [4:0] OP_AND  = 5'd10, OP_OR   = 5'd11, OP_ADDI = 5'd12, OP_ANDI = 5'd13;
    localparam logic [4:0] OP_ORI  = 5'd14, OP_MUL  = 5'd15, OP_DIV  = 5'd16, OP_NEG  = 5'd17;
    localparam logic [4:0] OP_NOT  = 5'd18, OP_BR   = 5'd19, OP_JR   = 5'd20, OP_IN   = 5'd22;
    localparam logic [4:0] OP_OUT  = 5'd23, OP_MFHI = 5'd24, OP_MFLO = 5'd25, OP_HALT = 5'd27;
    localparam logic [1:0] MW = 2'(MEM_WAIT);

    state_t     state_q, state_d, last_st;
    logic [1:0] wait_q, wait_d;
    logic [4:0] op_q, op_d;
    ctl_t       ctl_q, ctl_d;
    logic       is_alu, is_imm;

    function automatic logic [4:0] imm_alu_op(input logic [4:0] op);
        case (op)
            OP_ADDI: imm_alu_op = OP_ADD;
            OP_ANDI: imm_alu_op = OP_AND;
            default: imm_alu_op = OP_OR;
        endcase
    endfunction

    assign is_alu = (op_q >= OP_ADD) && (op_q <= OP_OR);
    assign is_imm = (op_q >= OP_ADDI) && (op_q <= OP_ORI);

    always_comb begin
        last_st = S_T3;
        if (is_alu || is_imm || op_q == OP_LDI)                              last_st = S_T5;
        else if (op_q == OP_MUL || op_q == OP_DIV || op_q == OP_BR)          last_st = S_T6;
        else if (op_q == OP_NEG || op_q == OP_NOT)                           last_st = S_T4;
        else if (op_q == OP_LD || op_q == OP_ST)                             last_st = S_T7;
    end

    // Memory-read steps (fetch T1, ld T6) are held for MEM_WAIT extra clocks.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        op_d    = op_q;
        case (state_q)
            S_T0: state_d = S_T1;
            S_T1: begin
                if (wait_q != MW) begin
                    wait_d = wait_q + 2'd1;
                end else begin
                    wait_d  = '0;
                    state_d = S_T2;
                end
            end
            S_T2: begin
                op_d    = bus.ir[31:27];
                state_d = S_T3;
            end
            S_HALT: state_d = S_HALT;
            default: begin
                if (state_q == S_T6 && op_q == OP_LD && wait_q != MW) begin
                    wait_d = wait_q + 2'd1;
                end else begin
                    wait_d = '0;
                    if (state_q == last_st)
                        state_d = (op_q == OP_HALT || bus.stop) ? S_HALT : S_T0;
                    else
                        state_d = state_t'(state_q + 4'd1);
                end
            end
        endcase
    end

    always_comb begin
        ctl_d        = '0;
        ctl_d.opcode = OP_ADD;
        ctl_d.run    = 1'b1;
        case (state_q)
            S_T0: begin ctl_d.PCout = 1'b1; ctl_d.MARin = 1'b1; ctl_d.IncPC = 1'b1; ctl_d.Zin = 1'b1; end
            S_T1: begin ctl_d.Z_lo_reg_out = 1'b1; ctl_d.PCin = 1'b1; ctl_d.Read = 1'b1; ctl_d.MDR_reg_in = 1'b1; end
            S_T2: begin ctl_d.MDR_reg_out = 1'b1; ctl_d.IR_reg_in = 1'b1; end
            S_HALT: ctl_d.run = 1'b0;
            default: begin
                if (is_alu || is_imm) begin
                    case (state_q)
                        S_T3: begin ctl_d.Grb = 1'b1; ctl_d.Rout = 1'b1; ctl_d.Y_reg_in = 1'b1; end
                        S_T4: begin
                            ctl_d.Zin = 1'b1;
                            if (is_imm) begin
                                ctl_d.Cout   = 1'b1;
                                ctl_d.opcode = imm_alu_op(op_q);
                            end else begin
                                ctl_d.Grc    = 1'b1;
                                ctl_d.Rout   = 1'b1;
                                ctl_d.opcode = op_q;
                            end
                        end
                        S_T5: begin ctl_d.Z_lo_reg_out = 1'b1; ctl_d.Gra = 1'b1; ctl_d.Rin = 1'b1; end
                        default: ;
                    endcase
                end else begin
                    case (op_q)
                        OP_MUL, OP_DIV: begin
                            case (state_q)
                                S_T3: begin ctl_d.Gra = 1'b1; ctl_d.Rout = 1'b1; ctl_d.Y_reg_in = 1'b1; end
                                S_T4: begin ctl_d.Grb = 1'b1; ctl_d.Rout = 1'b1; ctl_d.Zin = 1'b1; ctl_d.opcode = op_q; end
                                S_T5: begin ctl_d.Z_lo_reg_out = 1'b1; ctl_d.LO_reg_in = 1'b1; end
                                S_T6: begin ctl_d.Z_hi_reg_out = 1'b1; ctl_d.HI_reg_in = 1'b1; end
                                default: ;
                            endcase
                        end
                        OP_NEG, OP_NOT: begin
                            if (state_q == S_T3) begin
                                ctl_d.Grb = 1'b1; ctl_d.Rout = 1'b1; ctl_d.Zin = 1'b1; ctl_d.opcode = op_q;
                            end else begin
                                ctl_d.Z_lo_reg_out = 1'b1; ctl_d.Gra = 1'b1; ctl_d.Rin = 1'b1;
                            end
                        end
                        OP_LD, OP_LDI, OP_ST: begin
                            case (state_q)
                                S_T3: begin ctl_d.Grb = 1'b1; ctl_d.BAout = 1'b1; ctl_d.Y_reg_in = 1'b1; end
                                S_T4: begin ctl_d.Cout = 1'b1; ctl_d.Zin = 1'b1; end
                                S_T5: begin
                                    ctl_d.Z_lo_reg_out = 1'b1;
                                    if (op_q == OP_LDI) begin ctl_d.Gra = 1'b1; ctl_d.Rin = 1'b1; end
                                    else                 ctl_d.MARin = 1'b1;
                                end
                                S_T6: begin
                                    ctl_d.MDR_reg_in = 1'b1;
                                    if (op_q == OP_LD) ctl_d.Read = 1'b1;
                                    else begin ctl_d.Gra = 1'b1; ctl_d.Rout = 1'b1; end
                                end
                                S_T7: begin
                                    if (op_q == OP_LD) begin ctl_d.MDR_reg_out = 1'b1; ctl_d.Gra = 1'b1; ctl_d.Rin = 1'b1; end
                                    else               ctl_d.Write = 1'b1;
                                end
                                default: ;
                            endcase
                        end
                        OP_BR: begin
                            case (state_q)
                                S_T3: begin ctl_d.Gra = 1'b1; ctl_d.Rout = 1'b1; ctl_d.CON_enable = 1'b1; end
                                S_T4: begin ctl_d.PCout = 1'b1; ctl_d.Y_reg_in = 1'b1; end
                                S_T5: begin ctl_d.Cout = 1'b1; ctl_d.Zin = 1'b1; end
                                S_T6: begin ctl_d.Z_lo_reg_out = 1'b1; ctl_d.PCin = bus.con_ff; end
                                default: ;
                            endcase
                        end
                        OP_JR:   begin ctl_d.Gra = 1'b1; ctl_d.Rout = 1'b1; ctl_d.PCin = 1'b1; end
                        OP_IN:   begin ctl_d.InPort_out = 1'b1; ctl_d.Gra = 1'b1; ctl_d.Rin = 1'b1; end
                        OP_OUT:  begin ctl_d.Gra = 1'b1; ctl_d.Rout = 1'b1; ctl_d.Output_in = 1'b1; end
                        OP_MFHI: begin ctl_d.HI_reg_out = 1'b1; ctl_d.Gra = 1'b1; ctl_d.Rin = 1'b1; end
                        OP_MFLO: begin ctl_d.LO_reg_out = 1'b1; ctl_d.Gra = 1'b1; ctl_d.Rin = 1'b1; end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q      <= S_T0;
            wait_q       <= '0;
            op_q         <= '0;
            ctl_q        <= '0;
            ctl_q.opcode <= OP_ADD;
            ctl_q.run    <= 1'b1;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            op_q    <= op_d;
            ctl_q   <= ctl_d;
        end
    end

    assign bus.PCout        = ctl_q.PCout;
    assign bus.Z_hi_reg_out = ctl_q.Z_hi_reg_out;
    assign bus.Z_lo_reg_out = ctl_q.Z_lo_reg_out;
    assign bus.MDR_reg_out  = ctl_q.MDR_reg_out;
    assign bus.HI_reg_out   = ctl_q.HI_reg_out;
    assign bus.LO_reg_out   = ctl_q.LO_reg_out;
    assign bus.InPort_out   = ctl_q.InPort_out;
    assign bus.Cout         = ctl_q.Cout;
    assign bus.BAout        = ctl_q.BAout;
    assign bus.Rout         = ctl_q.Rout;
    assign bus.MARin        = ctl_q.MARin;
    assign bus.MDR_reg_in   = ctl_q.MDR_reg_in;
    assign bus.PCin         = ctl_q.PCin;
    assign bus.IR_reg_in    = ctl_q.IR_reg_in;
    assign bus.Y_reg_in     = ctl_q.Y_reg_in;
    assign bus.Zin          = ctl_q.Zin;
    assign bus.HI_reg_in    = ctl_q.HI_reg_in;
    assign bus.LO_reg_in    = ctl_q.LO_reg_in;
    assign bus.Rin          = ctl_q.Rin;
    assign bus.CON_enable   = ctl_q.CON_enable;
    assign bus.Output_in    = ctl_q.Output_in;
    assign bus.Gra          = ctl_q.Gra;
    assign bus.Grb          = ctl_q.Grb;
    assign bus.Grc          = ctl_q.Grc;
    assign bus.IncPC        = ctl_q.IncPC;
    assign bus.Read         = ctl_q.Read;
    assign bus.Write        = ctl_q.Write;
    assign bus.opcode       = ctl_q.opcode;
    assign bus.run          = ctl_q.run;
endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: three instances (MEM_WAIT 0, 1, 2) share stimulus and
// each step's full strobe/opcode/run vector is compared against hand-built expected sequences.
module tb_control_sequencer;
    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic [31:0] ir = '0;
    logic        con_ff = 1'b0;
    logic        stop = 1'b0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    control_sequencer_if b0 ();
    control_sequencer_if b1 ();
    control_sequencer_if b2 ();

    assign b0.ir = ir;  assign b0.con_ff = con_ff;  assign b0.stop = stop;
    assign b1.ir = ir;  assign b1.con_ff = con_ff;  assign b1.stop = stop;
    assign b2.ir = ir;  assign b2.con_ff = con_ff;  assign b2.stop = stop;

    control_sequencer #(.MEM_WAIT(0)) dut0 (.clk(clk), .clr(clr), .bus(b0));
    control_sequencer #(.MEM_WAIT(1)) dut1 (.clk(clk), .clr(clr), .bus(b1));
    control_sequencer #(.MEM_WAIT(2)) dut2 (.clk(clk), .clr(clr), .bus(b2));

    // Observed vector layout: {run, opcode[4:0], strobes[26:0]}
    logic [32:0] sig0, sig1, sig2;
    assign sig0 = {b0.run, b0.opcode, b0.Write, b0.Read, b0.IncPC, b0.Grc, b0.Grb, b0.Gra, b0.Output_in,
                   b0.CON_enable, b0.Rin, b0.LO_reg_in, b0.HI_reg_in, b0.Zin, b0.Y_reg_in, b0.IR_reg_in,
                   b0.PCin, b0.MDR_reg_in, b0.MARin, b0.Rout, b0.BAout, b0.Cout, b0.InPort_out,
                   b0.LO_reg_out, b0.HI_reg_out, b0.MDR_reg_out, b0.Z_lo_reg_out, b0.Z_hi_reg_out, b0.PCout};
    assign sig1 = {b1.run, b1.opcode, b1.Write, b1.Read, b1.IncPC, b1.Grc, b1.Grb, b1.Gra, b1.Output_in,
                   b1.CON_enable, b1.Rin, b1.LO_reg_in, b1.HI_reg_in, b1.Zin, b1.Y_reg_in, b1.IR_reg_in,
                   b1.PCin, b1.MDR_reg_in, b1.MARin, b1.Rout, b1.BAout, b1.Cout, b1.InPort_out,
                   b1.LO_reg_out, b1.HI_reg_out, b1.MDR_reg_out, b1.Z_lo_reg_out, b1.Z_hi_reg_out, b1.PCout};
    assign sig2 = {b2.run, b2.opcode, b2.Write, b2.Read, b2.IncPC, b2.Grc, b2.Grb, b2.Gra, b2.Output_in,
                   b2.CON_enable, b2.Rin, b2.LO_reg_in, b2.HI_reg_in, b2.Zin, b2.Y_reg_in, b2.IR_reg_in,
                   b2.PCin, b2.MDR_reg_in, b2.MARin, b2.Rout, b2.BAout, b2.Cout, b2.InPort_out,
                   b2.LO_reg_out, b2.HI_reg_out, b2.MDR_reg_out, b2.Z_lo_reg_out, b2.Z_hi_reg_out, b2.PCout};

    localparam logic [26:0] PCOUT = 27'd1 << 0,  ZHI   = 27'd1 << 1,  ZLO   = 27'd1 << 2,  MDROUT = 27'd1 << 3;
    localparam logic [26:0] HIOUT = 27'd1 << 4,  LOOUT = 27'd1 << 5,  INPRT = 27'd1 << 6,  COUT   = 27'd1 << 7;
    localparam logic [26:0] BAOUT = 27'd1 << 8,  ROUT  = 27'd1 << 9,  MARIN = 27'd1 << 10, MDRIN  = 27'd1 << 11;
    localparam logic [26:0] PCIN  = 27'd1 << 12, IRIN  = 27'd1 << 13, YIN   = 27'd1 << 14, ZIN    = 27'd1 << 15;
    localparam logic [26:0] HIIN  = 27'd1 << 16, LOIN  = 27'd1 << 17, RIN   = 27'd1 << 18, CONEN  = 27'd1 << 19;
    localparam logic [26:0] OUTIN = 27'd1 << 20, GRA   = 27'd1 << 21, GRB   = 27'd1 << 22, GRC    = 27'd1 << 23;
    localparam logic [26:0] INCPC = 27'd1 << 24, READ  = 27'd1 << 25, WRITE = 27'd1 << 26;

    localparam logic [32:0] RSTV = {1'b1, 5'd3, 27'd0};
    localparam logic [32:0] HV   = {1'b0, 5'd3, 27'd0};
    localparam logic [32:0] NOPV = {1'b1, 5'd3, 27'd0};
    localparam logic [32:0] F0V  = {1'b1, 5'd3, PCOUT | MARIN | INCPC | ZIN};
    localparam logic [32:0] F1V  = {1'b1, 5'd3, ZLO | PCIN | READ | MDRIN};
    localparam logic [32:0] F2V  = {1'b1, 5'd3, MDROUT | IRIN};
    localparam logic [32:0] RBY  = {1'b1, 5'd3, GRB | ROUT | YIN};
    localparam logic [32:0] WBV  = {1'b1, 5'd3, ZLO | GRA | RIN};
    localparam logic [32:0] BAY  = {1'b1, 5'd3, GRB | BAOUT | YIN};
    localparam logic [32:0] CZV  = {1'b1, 5'd3, COUT | ZIN};
    localparam logic [32:0] MARV = {1'b1, 5'd3, ZLO | MARIN};

    logic [32:0] e0[$], e1[$], e2[$];

    function automatic logic [32:0] mk(input logic [26:0] s, input logic [4:0] op);
        return {1'b1, op, s};
    endfunction

    function automatic int nmax();
        int n = e0.size();
        if (e1.size() > n) n = e1.size();
        if (e2.size() > n) n = e2.size();
        return n;
    endfunction

    task automatic clear_q();
        e0.delete(); e1.delete(); e2.delete();
    endtask

    task automatic push(input int d, input logic [32:0] v);
        case (d)
            0:       e0.push_back(v);
            1:       e1.push_back(v);
            default: e2.push_back(v);
        endcase
    endtask

    // Reset vector, T0, T1 held (1+w) clocks, T2.
    task automatic push_fetch(input int d, input int w);
        push(d, RSTV);
        push(d, F0V);
        for (int k = 0; k <= w; k++) push(d, F1V);
        push(d, F2V);
    endtask

    // Two reset edges; returns at the negedge where clr drops, with reset values visible.
    task automatic do_reset();
        @(negedge clk) clr = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk) clr = 1'b0;
    endtask

    task automatic test_reset();
        ir = 32'h78000000; con_ff = 1'b0; stop = 1'b0;
        do_reset();
        repeat (3) @(negedge clk);
        clear_q();
        push_fetch(0, 0); push_fetch(1, 1); push_fetch(2, 2);
        do_reset();
        for (int i = 0; i < nmax(); i++) begin
            if (i > 0) @(negedge clk);
            if (i < e0.size()) begin checks++; if (sig0 !== e0[i]) begin failures++; $display("FAIL reset w0 step %0d: got %h expected %h", i, sig0, e0[i]); end end
            if (i < e1.size()) begin checks++; if (sig1 !== e1[i]) begin failures++; $display("FAIL reset w1 step %0d: got %h expected %h", i, sig1, e1[i]); end end
            if (i < e2.size()) begin checks++; if (sig2 !== e2[i]) begin failures++; $display("FAIL reset w2 step %0d: got %h expected %h", i, sig2, e2[i]); end end
        end
        $display("reset: mid-instruction clr, fetch timing for MEM_WAIT 0/1/2 checked");
    endtask

    task automatic test_add();
        ir = 32'h18000000; stop = 1'b0;
        clear_q();
        push_fetch(0, 0); push(0, RBY); push(0, mk(GRC | ROUT | ZIN, 5'd3)); push(0, WBV); push(0, F0V);
        push_fetch(2, 2); push(2, RBY); push(2, mk(GRC | ROUT | ZIN, 5'd3)); push(2, WBV); push(2, F0V);
        do_reset();
        for (int i = 0; i < nmax(); i++) begin
            if (i > 0) @(negedge clk);
            if (i < e0.size()) begin checks++; if (sig0 !== e0[i]) begin failures++; $display("FAIL add w0 step %0d: got %h expected %h", i, sig0, e0[i]); end end
            if (i < e2.size()) begin checks++; if (sig2 !== e2[i]) begin failures++; $display("FAIL add w2 step %0d: got %h expected %h", i, sig2, e2[i]); end end
            if (i == 5) ir = 32'hD8000000;
        end
        $display("add: ir=18000000 sequence checked at MEM_WAIT 0 and 2, ir changed after latch");
    endtask

    task automatic test_alu_ops();
        for (int c = 0; c < 15; c++) begin
            clear_q();
            push_fetch(0, 0);
            case (c)
                0:  begin ir = 32'h20000000; push(0, RBY); push(0, mk(GRC | ROUT | ZIN, 5'd4));  push(0, WBV); end
                1:  begin ir = 32'h60000000; push(0, RBY); push(0, mk(COUT | ZIN, 5'd3));        push(0, WBV); end
                2:  begin ir = 32'h68000000; push(0, RBY); push(0, mk(COUT | ZIN, 5'd10));       push(0, WBV); end
                3:  begin ir = 32'h70000000; push(0, RBY); push(0, mk(COUT | ZIN, 5'd11));       push(0, WBV); end
                4:  begin ir = 32'h88000000; push(0, mk(GRB | ROUT | ZIN, 5'd17)); push(0, WBV); end
                5:  begin ir = 32'h90000000; push(0, mk(GRB | ROUT | ZIN, 5'd18)); push(0, WBV); end
                6:  begin ir = 32'h08000000; push(0, BAY); push(0, CZV); push(0, WBV); end
                7:  begin ir = 32'h80000000; push(0, mk(GRA | ROUT | YIN, 5'd3)); push(0, mk(GRB | ROUT | ZIN, 5'd16));
                          push(0, mk(ZLO | LOIN, 5'd3)); push(0, mk(ZHI | HIIN, 5'd3)); end
                8:  begin ir = 32'hD0000000; push(0, NOPV); end
                9:  begin ir = 32'hA8000000; push(0, NOPV); end
                10: begin ir = 32'hF8000000; push(0, NOPV); end
                11: begin ir = 32'hB0000000; push(0, mk(INPRT | GRA | RIN, 5'd3)); end
                12: begin ir = 32'hB8000000; push(0, mk(GRA | ROUT | OUTIN, 5'd3)); end
                13: begin ir = 32'hC8000000; push(0, mk(LOOUT | GRA | RIN, 5'd3)); end
                default: begin ir = 32'h50000000; push(0, RBY); push(0, mk(GRC | ROUT | ZIN, 5'd10)); push(0, WBV); end
            endcase
            push(0, F0V);
            do_reset();
            for (int i = 0; i < nmax(); i++) begin
                if (i > 0) @(negedge clk);
                if (i < e0.size()) begin checks++; if (sig0 !== e0[i]) begin failures++; $display("FAIL alu_ops ir=%h step %0d: got %h expected %h", ir, i, sig0, e0[i]); end end
            end
            $display("alu_ops: ir=%h sequence checked", ir);
        end
    endtask

    task automatic test_ld();
        ir = 32'h03000002; stop = 1'b0;
        clear_q();
        for (int d = 0; d < 3; d++) begin
            push_fetch(d, d);
            push(d, BAY); push(d, CZV); push(d, MARV);
            for (int k = 0; k <= d; k++) push(d, {1'b1, 5'd3, READ | MDRIN});
            push(d, {1'b1, 5'd3, MDROUT | GRA | RIN});
            push(d, F0V);
        end
        do_reset();
        for (int i = 0; i < nmax(); i++) begin
            if (i > 0) @(negedge clk);
            if (i < e0.size()) begin checks++; if (sig0 !== e0[i]) begin failures++; $display("FAIL ld w0 step %0d: got %h expected %h", i, sig0, e0[i]); end end
            if (i < e1.size()) begin checks++; if (sig1 !== e1[i]) begin failures++; $display("FAIL ld w1 step %0d: got %h expected %h", i, sig1, e1[i]); end end
            if (i < e2.size()) begin checks++; if (sig2 !== e2[i]) begin failures++; $display("FAIL ld w2 step %0d: got %h expected %h", i, sig2, e2[i]); end end
        end
        $display("ld: ir=03000002 sequence with T6 held 1/2/3 clocks checked");
    endtask

    task automatic test_store();
        ir = 32'h10000000; stop = 1'b0;
        clear_q();
        for (int d = 0; d < 3; d++) begin
            push_fetch(d, d);
            push(d, BAY); push(d, CZV); push(d, MARV);
            push(d, {1'b1, 5'd3, GRA | ROUT | MDRIN});
            push(d, {1'b1, 5'd3, WRITE});
            push(d, F0V);
        end
        do_reset();
        for (int i = 0; i < nmax(); i++) begin
            if (i > 0) @(negedge clk);
            if (i < e0.size()) begin checks++; if (sig0 !== e0[i]) begin failures++; $display("FAIL st w0 step %0d: got %h expected %h", i, sig0, e0[i]); end end
            if (i < e1.size()) begin checks++; if (sig1 !== e1[i]) begin failures++; $display("FAIL st w1 step %0d: got %h expected %h", i, sig1, e1[i]); end end
            if (i < e2.size()) begin checks++; if (sig2 !== e2[i]) begin failures++; $display("FAIL st w2 step %0d: got %h expected %h", i, sig2, e2[i]); end end
        end
        $display("st: ir=10000000 sequence checked, T6 never held");
    endtask

    task automatic test_branch();
        for (int cf = 0; cf < 2; cf++) begin
            ir = 32'h9B000019; stop = 1'b0; con_ff = cf[0];
            clear_q();
            push_fetch(0, 0);
            push(0, {1'b1, 5'd3, GRA | ROUT | CONEN});
            push(0, {1'b1, 5'd3, PCOUT | YIN});
            push(0, CZV);
            push(0, {1'b1, 5'd3, ZLO | (cf[0] ? PCIN : 27'd0)});
            push(0, F0V);
            do_reset();
            for (int i = 0; i < nmax(); i++) begin
                if (i > 0) @(negedge clk);
                if (i < e0.size()) begin checks++; if (sig0 !== e0[i]) begin failures++; $display("FAIL br con_ff=%0d step %0d: got %h expected %h", cf, i, sig0, e0[i]); end end
            end
            $display("br: ir=9B000019 con_ff=%0d sequence checked", cf);
        end
        con_ff = 1'b0;
    endtask

    task automatic test_mul();
        ir = 32'h78000000; stop = 1'b0;
        clear_q();
        for (int d = 0; d < 2; d++) begin
            push_fetch(d, d);
            push(d, mk(GRA | ROUT | YIN, 5'd3));
            push(d, mk(GRB | ROUT | ZIN, 5'd15));
            push(d, mk(ZLO | LOIN, 5'd3));
            push(d, mk(ZHI | HIIN, 5'd3));
            push(d, F0V);
        end
        do_reset();
        for (int i = 0; i < nmax(); i++) begin
            if (i > 0) @(negedge clk);
            if (i < e0.size()) begin checks++; if (sig0 !== e0[i]) begin failures++; $display("FAIL mul w0 step %0d: got %h expected %h", i, sig0, e0[i]); end end
            if (i < e1.size()) begin checks++; if (sig1 !== e1[i]) begin failures++; $display("FAIL mul w1 step %0d: got %h expected %h", i, sig1, e1[i]); end end
        end
        $display("mul: ir=78000000 LO/HI load steps checked");
    endtask

    task automatic test_back_to_back();
        ir = 32'hA0000000; stop = 1'b0;
        clear_q();
        push_fetch(0, 0);
        push(0, {1'b1, 5'd3, GRA | ROUT | PCIN});
        push(0, F0V); push(0, F1V); push(0, F2V);
        push(0, {1'b1, 5'd3, HIOUT | GRA | RIN});
        push(0, F0V);
        do_reset();
        for (int i = 0; i < nmax(); i++) begin
            if (i > 0) @(negedge clk);
            if (i < e0.size()) begin checks++; if (sig0 !== e0[i]) begin failures++; $display("FAIL back_to_back step %0d: got %h expected %h", i, sig0, e0[i]); end end
            if (i == 5) ir = 32'hC0000000;
        end
        $display("back_to_back: jr then mfhi checked");
    endtask

    task automatic test_halt();
        ir = 32'hD8000000; stop = 1'b0; con_ff = 1'b0;
        clear_q();
        push_fetch(0, 0);
        push(0, NOPV);
        for (int k = 0; k < 12; k++) push(0, HV);
        do_reset();
        for (int i = 0; i < nmax(); i++) begin
            if (i > 0) @(negedge clk);
            if (i < e0.size()) begin checks++; if (sig0 !== e0[i]) begin failures++; $display("FAIL halt step %0d: got %h expected %h", i, sig0, e0[i]); end end
            if (i == 9) begin stop = 1'b1; ir = 32'h18000000; con_ff = 1'b1; end
        end
        $display("halt: ir=D8000000 holds HALT for 12 clocks");
        ir = 32'hD0000000; stop = 1'b0; con_ff = 1'b0;
        clear_q();
        push_fetch(0, 0); push(0, NOPV); push(0, F0V);
        do_reset();
        for (int i = 0; i < nmax(); i++) begin
            if (i > 0) @(negedge clk);
            if (i < e0.size()) begin checks++; if (sig0 !== e0[i]) begin failures++; $display("FAIL halt_exit step %0d: got %h expected %h", i, sig0, e0[i]); end end
        end
        $display("halt: clr from HALT restarts fetch");
    endtask

    task automatic test_stop();
        for (int p = 0; p < 2; p++) begin
            stop = 1'b1;
            clear_q();
            if (p == 0) begin
                ir = 32'hD0000000;
                push_fetch(0, 0); push(0, NOPV);
                for (int k = 0; k < 3; k++) push(0, HV);
            end else begin
                ir = 32'h18000000;
                push_fetch(2, 2); push(2, RBY); push(2, mk(GRC | ROUT | ZIN, 5'd3)); push(2, WBV);
                for (int k = 0; k < 3; k++) push(2, HV);
            end
            do_reset();
            for (int i = 0; i < nmax(); i++) begin
                if (i > 0) @(negedge clk);
                if (i < e0.size()) begin checks++; if (sig0 !== e0[i]) begin failures++; $display("FAIL stop nop step %0d: got %h expected %h", i, sig0, e0[i]); end end
                if (i < e2.size()) begin checks++; if (sig2 !== e2[i]) begin failures++; $display("FAIL stop add w2 step %0d: got %h expected %h", i, sig2, e2[i]); end end
            end
            $display("stop: ir=%h halts at instruction boundary", ir);
        end
        stop = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_alu_ops();
        test_ld();
        test_store();
        test_branch();
        test_mul();
        test_back_to_back();
        test_halt();
        test_stop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired Moore control unit that sequences the single-bus CPU datapath.
- Performs fetch (T0–T2), then decodes IR[31:27] and steps through execute states, emitting the datapath strobes, the ALU opcode and a run flag.
- Output names match the datapath ports one-for-one, so the block wires directly in place of a hand-driven testbench.

Parameters:
- MEM_WAIT, 0: extra cycles the memory-read step is held (Read and MDR_reg_in stay high). Applies to fetch T1 and ld T6. Range 0–3.

Ports:
- clk  in  1  system clock, rising edge
- clr  in  1  synchronous active-high reset
- ir  in  32  IR contents; opcode = ir[31:27]
- con_ff  in  1  CON FF result (branch taken)
- stop  in  1  request halt at the next instruction boundary
- PCout, Z_hi_reg_out, Z_lo_reg_out, MDR_reg_out, HI_reg_out, LO_reg_out, InPort_out, Cout, BAout, Rout  out  1 each  bus-drive strobes
- MARin, MDR_reg_in, PCin, IR_reg_in, Y_reg_in, Zin, HI_reg_in, LO_reg_in, Rin, CON_enable, Output_in  out  1 each  register-load strobes
- Gra, Grb, Grc  out  1 each  register-select field enables
- IncPC, Read, Write  out  1 each  PC increment, memory read, memory write
- opcode  out  5  ALU operation
- run  out  1  1 while executing; 0 in HALT

Behaviour:
- Outputs are a pure decode of the state register (Moore). Each step lasts exactly one clock, except memory-read steps, which last 1+MEM_WAIT clocks.
- Reset: clr=1 at a clock edge sends the state to T0 and clears the wait counter. This holds from any state, including mid-instruction and HALT.
- Reset values: every strobe is 0, opcode=5'b00011, run=1.
- Fetch:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Z_lo_reg_out, PCin, Read, MDR_reg_in.
  - T2: MDR_reg_out, IR_reg_in.
- Execute (steps start at T3). opcode=00011 (ADD) whenever Zin is used for an address or PC computation.
  - Reg ALU (00011–01011 add,sub,shr,shra,shl,ror,rol,and,or): T3 Grb,Rout,Y_reg_in; T4 Grc,Rout,Zin, opcode=ir[31:27]; T5 Z_lo_reg_out,Gra,Rin.
  - Immediate (01100 addi, 01101 andi, 01110 ori): as Reg ALU, but T4 uses Cout instead of Grc,Rout, with opcode mapped to 00011, 01010, 01011 respectively.
  - mul/div (01111, 10000): T3 Gra,Rout,Y_reg_in; T4 Grb,Rout,Zin, opcode=ir; T5 Z_lo_reg_out,LO_reg_in; T6 Z_hi_reg_out,HI_reg_in.
  - neg/not (10001, 10010): T3 Grb,Rout,Zin, opcode=ir; T4 Z_lo_reg_out,Gra,Rin.
  - ld (00000): T3 Grb,BAout,Y_reg_in; T4 Cout,Zin; T5 Z_lo_reg_out,MARin; T6 Read,MDR_reg_in; T7 MDR_reg_out,Gra,Rin.
  - ldi (00001): T3 Grb,BAout,Y_reg_in; T4 Cout,Zin; T5 Z_lo_reg_out,Gra,Rin.
  - st (00010): T3–T5 as ld; T6 Gra,Rout,MDR_reg_in (Read=0); T7 Write.
  - br (10011): T3 Gra,Rout,CON_enable; T4 PCout,Y_reg_in; T5 Cout,Zin; T6 Z_lo_reg_out, with PCin=con_ff sampled during T6.
  - jr (10100): T3 Gra,Rout,PCin.
  - in (10110): T3 InPort_out,Gra,Rin.
  - out (10111): T3 Gra,Rout,Output_in.
  - mfhi (11000): T3 HI_reg_out,Gra,Rin.
  - mflo (11001): T3 LO_reg_out,Gra,Rin.
  - nop (11010), and unimplemented 10101 (jal) and 11100–11111: no strobes; return to T0.
  - halt (11011): enter HALT.
- Decode: ir is sampled at the end of T2 and latched internally, so later IR changes do not alter the sequence.
- Instruction boundary: after the final execute step, go to T0. If stop=1 at that edge, go to HALT instead.
- HALT: all strobes 0, run=0. Leaves only on clr.
- Never assert Read and Write together, or two bus drivers in the same step.

Test Plan:
- Reset: clr=1 for 2 cycles from arbitrary state → T0, all strobes 0, run=1; next edge PCout=MARin=IncPC=Zin=1.
- add: ir=0x18000000 (opcode 00011) → T3 Grb/Rout/Y_reg_in, T4 Grc/Rout/Zin with opcode=00011, T5 Z_lo_reg_out/Gra/Rin, then T0. Total 6 cycles at MEM_WAIT=0; 8 cycles at MEM_WAIT=2 (T1 held 3 cycles).
- ld: ir=0x03000002, MEM_WAIT=1 → T6 Read+MDR_reg_in high for 2 cycles; T7 MDR_reg_out/Gra/Rin; Write never asserted.
- br: ir=0x9B000019 with con_ff=0 → T6 has PCin=0; repeat with con_ff=1 → PCin=1 in T6 only.
- mul: ir=0x78000000 → LO_reg_in in T5 and HI_reg_in in T6, each exactly one cycle.
- halt/stop: ir=0xD8000000 → run=0, all strobes 0 for 10+ cycles; clr → T0. Then stop=1 during a nop → HALT after T3.
